// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the instruction control sequencer:
// T-state encoding, ALU operation codes, IR field positions and opcode classifiers.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6
    } state_t;

    localparam int ALU_AND = 1;
    localparam int ALU_OR  = 2;
    localparam int ALU_SHL = 4;
    localparam int ALU_SHR = 5;
    localparam int ALU_ROR = 6;
    localparam int ALU_ROL = 7;
    localparam int ALU_ADD = 8;
    localparam int ALU_SUB = 9;
    localparam int ALU_MUL = 10;
    localparam int ALU_DIV = 11;
    localparam int ALU_NEG = 12;
    localparam int ALU_NOT = 13;

    // IR layout: opcode in the top bits, then dest/source register fields.
    localparam int IR_W   = 32;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    function automatic logic op_is_legal(input int op);
        case (op)
            ALU_AND, ALU_OR, ALU_SHL, ALU_SHR, ALU_ROR, ALU_ROL,
            ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_NEG, ALU_NOT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_muldiv(input int op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    // Single-operand ops take their only operand from Y; no Rc is driven.
    function automatic logic op_is_unary(input int op);
        return (op == ALU_NEG) || (op == ALU_NOT);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer and memory/IR/datapath.
// With STEP_MODE_EN defined the bundle also carries the single-step request.
interface control_sequencer_if #(
    parameter int NREG   = 16,
    parameter int CTRL_W = 4
) ();

    logic              start;
    logic [31:0]       ir;
    logic              mem_ready;
`ifdef STEP_MODE_EN
    logic              step_req;
`endif

    logic              pc_out;
    logic              zlow_out;
    logic              zhigh_out;
    logic              mdr_out;
    logic              mar_in;
    logic              pc_in;
    logic              ir_in;
    logic              y_in;
    logic              z_in;
    logic              hi_in;
    logic              lo_in;
    logic              mdr_read;
    logic              inc_pc;
    logic [NREG-1:0]   reg_in;
    logic [NREG-1:0]   reg_out;
    logic [CTRL_W-1:0] alu_control;
    logic              busy;
    logic              instr_done;

`ifdef STEP_MODE_EN
    modport master (
        input  start, ir, mem_ready, step_req,
        output pc_out, zlow_out, zhigh_out, mdr_out,
        output mar_in, pc_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_read, inc_pc,
        output reg_in, reg_out, alu_control, busy, instr_done
    );
    modport slave (
        output start, ir, mem_ready, step_req,
        input  pc_out, zlow_out, zhigh_out, mdr_out,
        input  mar_in, pc_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_read, inc_pc,
        input  reg_in, reg_out, alu_control, busy, instr_done
    );
`else
    modport master (
        input  start, ir, mem_ready,
        output pc_out, zlow_out, zhigh_out, mdr_out,
        output mar_in, pc_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_read, inc_pc,
        output reg_in, reg_out, alu_control, busy, instr_done
    );
    modport slave (
        output start, ir, mem_ready,
        input  pc_out, zlow_out, zhigh_out, mdr_out,
        input  mar_in, pc_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_read, inc_pc,
        input  reg_in, reg_out, alu_control, busy, instr_done
    );
`endif

endinterface

// File: rtl/reg_sel_decoder.sv
// Register-select field to one-hot GP register strobe, gated by an enable.
// Select values with no matching register produce an all-zero vector.
module reg_sel_decoder #(
    parameter int RSEL_W = 4,
    parameter int NREG   = 16
) (
    input  logic              en,
    input  logic [RSEL_W-1:0] sel,
    output logic [NREG-1:0]   onehot
);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            assign onehot[gi] = en && (int'(sel) == gi);
        end
    endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM issuing one-hot datapath strobes for fetch (T0-T2) and execute (T3-T6).
// Optional STEP_MODE_EN: every T-state holds until step_req is seen high.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int OP_W   = 5,
    parameter int RSEL_W = 4,
    parameter int CTRL_W = 4
) (
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.master bus
);

    state_t            state_reg;
    state_t            state_next;
    logic              t1_first_reg;
    logic [OP_W-1:0]   op_reg;
    logic [RSEL_W-1:0] ra_reg;
    logic [RSEL_W-1:0] rc_reg;

    logic [OP_W-1:0]   op_live;
    logic [RSEL_W-1:0] ra_live;
    logic [RSEL_W-1:0] rb_live;
    logic [RSEL_W-1:0] rc_live;
    logic              ir_low_unused;

    logic              step_ok;
    logic              op_legal;
    logic              op_muldiv;
    logic              op_unary;

    logic              rin_en;
    logic [RSEL_W-1:0] rin_sel;
    logic              rout_en;
    logic [RSEL_W-1:0] rout_sel;

    assign op_live       = bus.ir[IR_W-1 -: OP_W];
    assign ra_live       = bus.ir[RA_LSB +: RSEL_W];
    assign rb_live       = bus.ir[RB_LSB +: RSEL_W];
    assign rc_live       = bus.ir[RC_LSB +: RSEL_W];
    assign ir_low_unused = ^bus.ir[RC_LSB-1:0];

`ifdef STEP_MODE_EN
    assign step_ok = bus.step_req;
`else
    assign step_ok = 1'b1;
`endif

    assign op_legal  = op_is_legal(int'(op_reg));
    assign op_muldiv = op_legal && op_is_muldiv(int'(op_reg));
    assign op_unary  = op_legal && op_is_unary(int'(op_reg));

    // Fields are captured while the freshly loaded IR is presented in T3,
    // so the execute states do not depend on IR staying stable afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            t1_first_reg <= 1'b0;
            op_reg       <= '0;
            ra_reg       <= '0;
            rc_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            t1_first_reg <= (state_reg == T0);
            if (state_reg == T3) begin
                op_reg <= op_live;
                ra_reg <= ra_live;
                rc_reg <= rc_live;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.start) state_next = T0;
            T0:   if (step_ok) state_next = T1;
            T1:   if (step_ok && bus.mem_ready) state_next = T2;
            T2:   if (step_ok) state_next = T3;
            T3:   if (step_ok) state_next = T4;
            T4:   if (step_ok) state_next = T5;
            T5:   if (step_ok) state_next = op_muldiv ? T6 : IDLE;
            T6:   if (step_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.pc_out      = 1'b0;
        bus.zlow_out    = 1'b0;
        bus.zhigh_out   = 1'b0;
        bus.mdr_out     = 1'b0;
        bus.mar_in      = 1'b0;
        bus.pc_in       = 1'b0;
        bus.ir_in       = 1'b0;
        bus.y_in        = 1'b0;
        bus.z_in        = 1'b0;
        bus.hi_in       = 1'b0;
        bus.lo_in       = 1'b0;
        bus.mdr_read    = 1'b0;
        bus.inc_pc      = 1'b0;
        bus.alu_control = '0;
        bus.instr_done  = 1'b0;
        bus.busy        = (state_reg != IDLE);
        rin_en          = 1'b0;
        rin_sel         = ra_reg;
        rout_en         = 1'b0;
        rout_sel        = rc_reg;
        case (state_reg)
            T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
            end
            T1: begin
                // PC+1 sits in Z; load it once even if memory stretches T1.
                bus.zlow_out = 1'b1;
                bus.mdr_read = 1'b1;
                bus.pc_in    = t1_first_reg;
            end
            T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            T3: begin
                rout_en  = 1'b1;
                rout_sel = rb_live;
                bus.y_in = 1'b1;
            end
            T4: begin
                rout_en         = !op_unary;
                bus.z_in        = 1'b1;
                bus.alu_control = op_legal ? CTRL_W'(op_reg) : '0;
            end
            T5: begin
                bus.zlow_out   = 1'b1;
                bus.lo_in      = op_muldiv;
                rin_en         = op_legal && !op_muldiv;
                bus.instr_done = !op_muldiv;
            end
            T6: begin
                bus.zhigh_out  = 1'b1;
                bus.hi_in      = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    reg_sel_decoder #(
        .RSEL_W (RSEL_W),
        .NREG   (NREG)
    ) u_reg_in_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (bus.reg_in)
    );

    reg_sel_decoder #(
        .RSEL_W (RSEL_W),
        .NREG   (NREG)
    ) u_reg_out_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (bus.reg_out)
    );

endmodule
